// File: rtl/obi_cfg_arbiter_if.sv
// obi_cfg_arbiter_if: bus bundle around the config-register arbiter.
// m_* : NUM_REQ requesting OBI masters (request fields packed per master, response shared)
// s_* : the single OBI slave port of the config register block
// timeout_o : watchdog pulse
// modport master : the arbiter view (consumes master requests, drives the slave port as its master)
// modport slave  : the surrounding system view (requesting masters plus the config register block)
interface obi_cfg_arbiter_if #(parameter int NUM_REQ = 2);
  logic [NUM_REQ-1:0]    m_req_i;
  logic [NUM_REQ-1:0]    m_we_i;
  logic [4*NUM_REQ-1:0]  m_be_i;
  logic [32*NUM_REQ-1:0] m_addr_i;
  logic [32*NUM_REQ-1:0] m_wdata_i;
  logic [NUM_REQ-1:0]    m_gnt_o;
  logic [NUM_REQ-1:0]    m_rvalid_o;
  logic [31:0]           m_rdata_o;
  logic                  m_err_o;
  logic                  s_req_o;
  logic                  s_we_o;
  logic [3:0]            s_be_o;
  logic [31:0]           s_addr_o;
  logic [31:0]           s_wdata_o;
  logic                  s_gnt_i;
  logic                  s_rvalid_i;
  logic [31:0]           s_rdata_i;
  logic                  timeout_o;
  modport master (
    input  m_req_i, m_we_i, m_be_i, m_addr_i, m_wdata_i, s_gnt_i, s_rvalid_i, s_rdata_i,
    output m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o, s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o, timeout_o
  );
  modport slave (
    output m_req_i, m_we_i, m_be_i, m_addr_i, m_wdata_i, s_gnt_i, s_rvalid_i, s_rdata_i,
    input  m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o, s_req_o, s_we_o, s_be_o, s_addr_o, s_wdata_o, timeout_o
  );
endinterface

// File: rtl/obi_cfg_arbiter.sv
// obi_cfg_arbiter: round-robin sharing of the config-block OBI slave port among NUM_REQ masters,
// one outstanding transaction, watchdog-forced error response.
// clk_i, rst_ni : clock, asynchronous active-low reset
// bus           : obi_cfg_arbiter_if.master (master requests in, slave port out, responses routed back)
module obi_cfg_arbiter #(
  parameter int          NUM_REQ     = 2,
  parameter int          TIMEOUT_CYC = 64,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input logic                clk_i,
  input logic                rst_ni,
  obi_cfg_arbiter_if.master  bus
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int WW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  typedef enum logic [1:0] {ARB, HOLD, WAIT_RSP} state_e;
  state_e        state_q, state_d;
  logic [PW-1:0] prio_q, prio_d, owner_q, owner_d, win, idx, sel;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          found, act, take, rsp, to;
  always_comb begin
    found = 1'b0;
    win = prio_q;
    idx = '0;
    // first requester at or above prio_q, wrapping modulo NUM_REQ
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PW'((int'(prio_q) + i) % NUM_REQ);
      if (!found && bus.m_req_i[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
    sel = state_q == ARB ? win : owner_q;
    // HOLD stays locked to owner; a dropped owner request stops driving the slave
    act = state_q == ARB ? found : state_q == HOLD ? bus.m_req_i[owner_q] : 1'b0;
    take = act && bus.s_gnt_i;
    rsp = state_q == WAIT_RSP && bus.s_rvalid_i;
    to = state_q == WAIT_RSP && !bus.s_rvalid_i && wdog_q == WW'(TIMEOUT_CYC - 1);
    bus.s_req_o = act;
    bus.s_we_o = 1'b0;
    bus.s_be_o = '0;
    bus.s_addr_o = '0;
    bus.s_wdata_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (act && sel == PW'(k)) begin
        bus.s_we_o = bus.m_we_i[k];
        bus.s_be_o = bus.m_be_i[4*k +: 4];
        bus.s_addr_o = bus.m_addr_i[32*k +: 32];
        bus.s_wdata_o = bus.m_wdata_i[32*k +: 32];
      end
    end
    bus.m_gnt_o = take ? NUM_REQ'(1) << sel : '0;
    bus.m_rvalid_o = (rsp || to) ? NUM_REQ'(1) << owner_q : '0;
    bus.m_rdata_o = rsp ? bus.s_rdata_i : to ? ERR_RDATA : '0;
    bus.m_err_o = to;
    bus.timeout_o = to;
    state_d = state_q;
    prio_d = prio_q;
    owner_d = owner_q;
    wdog_d = wdog_q;
    case (state_q)
      ARB: if (found) begin
        owner_d = win;
        wdog_d = '0;
        state_d = take ? WAIT_RSP : HOLD;
      end
      HOLD: begin
        wdog_d = '0;
        state_d = !bus.m_req_i[owner_q] ? ARB : take ? WAIT_RSP : HOLD;
      end
      WAIT_RSP: begin
        wdog_d = wdog_q + 1'b1;
        if (rsp || to) begin
          state_d = ARB;
          prio_d = PW'((int'(owner_q) + 1) % NUM_REQ);
        end
      end
      default: state_d = ARB;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB;
      prio_q <= '0;
      owner_q <= '0;
      wdog_q <= '0;
    end else begin
      state_q <= state_d;
      prio_q <= prio_d;
      owner_q <= owner_d;
      wdog_q <= wdog_d;
    end
  end
endmodule

// File: tb/tb_obi_cfg_arbiter.sv
// tb_obi_cfg_arbiter: directed checks of the config-port arbiter (2 masters, 4-cycle watchdog).
module tb_obi_cfg_arbiter;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   total = 0;
  int   passed = 0;
  obi_cfg_arbiter_if #(.NUM_REQ(2)) bus ();
  obi_cfg_arbiter #(.NUM_REQ(2), .TIMEOUT_CYC(4), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .bus(bus)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic nxt;
    @(posedge clk_i);
    #1;
  endtask
  task automatic smp;
    #4;
  endtask
  task automatic idle;
    bus.m_req_i = '0;
    bus.m_we_i = '0;
    bus.m_be_i = '0;
    bus.m_addr_i = '0;
    bus.m_wdata_i = '0;
    bus.s_gnt_i = 1'b0;
    bus.s_rvalid_i = 1'b0;
    bus.s_rdata_i = '0;
  endtask
  initial begin
    idle();
    nxt();
    nxt();
    smp();
    chk("rst_gnt", 32'(bus.m_gnt_o), 32'h0);
    chk("rst_rvalid", 32'(bus.m_rvalid_o), 32'h0);
    chk("rst_sreq", 32'(bus.s_req_o), 32'h0);
    chk("rst_saddr", bus.s_addr_o, 32'h0);
    chk("rst_rdata", bus.m_rdata_o, 32'h0);
    chk("rst_timeout", 32'(bus.timeout_o), 32'h0);
    nxt();
    rst_ni = 1'b1;
    nxt();
    // single write from master 0
    bus.m_req_i = 2'b01;
    bus.m_we_i = 2'b01;
    bus.m_be_i = 8'h01;
    bus.m_addr_i = {32'h0, 32'h0};
    bus.m_wdata_i = {32'h0, 32'h1};
    bus.s_gnt_i = 1'b1;
    smp();
    chk("wr_gnt", 32'(bus.m_gnt_o), 32'h1);
    chk("wr_sreq", 32'(bus.s_req_o), 32'h1);
    chk("wr_swe", 32'(bus.s_we_o), 32'h1);
    chk("wr_sbe", 32'(bus.s_be_o), 32'h1);
    chk("wr_swdata", bus.s_wdata_o, 32'h1);
    nxt();
    idle();
    bus.s_rvalid_i = 1'b1;
    smp();
    chk("wr_rvalid", 32'(bus.m_rvalid_o), 32'h1);
    chk("wr_err", 32'(bus.m_err_o), 32'h0);
    chk("wr_rsp_gnt", 32'(bus.m_gnt_o), 32'h0);
    chk("wr_rsp_sreq", 32'(bus.s_req_o), 32'h0);
    nxt();
    // read by master 1 (prio now 1)
    idle();
    bus.m_req_i = 2'b10;
    bus.m_addr_i = {32'h4, 32'h0};
    bus.s_gnt_i = 1'b1;
    smp();
    chk("rd_gnt", 32'(bus.m_gnt_o), 32'h2);
    chk("rd_saddr", bus.s_addr_o, 32'h4);
    chk("rd_swe", 32'(bus.s_we_o), 32'h0);
    nxt();
    idle();
    bus.s_rvalid_i = 1'b1;
    bus.s_rdata_i = 32'h1234_5678;
    smp();
    chk("rd_rvalid", 32'(bus.m_rvalid_o), 32'h2);
    chk("rd_rdata", bus.m_rdata_o, 32'h1234_5678);
    nxt();
    bus.s_rvalid_i = 1'b0;
    smp();
    chk("rd_after_rdata", bus.m_rdata_o, 32'h0);
    chk("rd_after_rvalid", 32'(bus.m_rvalid_o), 32'h0);
    nxt();
    // both masters requesting continuously: 0,1,0,1
    bus.m_req_i = 2'b11;
    bus.m_addr_i = {32'h20, 32'h10};
    bus.s_gnt_i = 1'b1;
    for (int t = 0; t < 4; t++) begin
      bus.s_rvalid_i = 1'b0;
      smp();
      chk($sformatf("alt_gnt%0d", t), 32'(bus.m_gnt_o), (t % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("alt_saddr%0d", t), bus.s_addr_o, (t % 2 == 0) ? 32'h10 : 32'h20);
      nxt();
      bus.s_rvalid_i = 1'b1;
      smp();
      chk($sformatf("alt_gap%0d", t), 32'(bus.m_gnt_o), 32'h0);
      chk($sformatf("alt_rvalid%0d", t), 32'(bus.m_rvalid_o), (t % 2 == 0) ? 32'h1 : 32'h2);
      nxt();
    end
    // slave stalls; master 1 arriving later cannot preempt master 0
    idle();
    bus.m_req_i = 2'b01;
    bus.m_addr_i = {32'h200, 32'h100};
    smp();
    chk("hold_gnt0", 32'(bus.m_gnt_o), 32'h0);
    chk("hold_saddr0", bus.s_addr_o, 32'h100);
    nxt();
    bus.m_req_i = 2'b11;
    for (int t = 1; t < 3; t++) begin
      smp();
      chk($sformatf("hold_gnt%0d", t), 32'(bus.m_gnt_o), 32'h0);
      chk($sformatf("hold_saddr%0d", t), bus.s_addr_o, 32'h100);
      nxt();
    end
    bus.s_gnt_i = 1'b1;
    smp();
    chk("hold_gnt_final", 32'(bus.m_gnt_o), 32'h1);
    chk("hold_saddr_final", bus.s_addr_o, 32'h100);
    nxt();
    bus.m_req_i = 2'b00;
    bus.s_gnt_i = 1'b0;
    bus.s_rvalid_i = 1'b1;
    smp();
    chk("hold_rvalid", 32'(bus.m_rvalid_o), 32'h1);
    nxt();
    // watchdog: master 1 granted, slave never answers
    idle();
    bus.m_req_i = 2'b10;
    bus.m_addr_i = {32'h8, 32'h0};
    bus.s_gnt_i = 1'b1;
    smp();
    chk("to_gnt", 32'(bus.m_gnt_o), 32'h2);
    nxt();
    idle();
    for (int t = 1; t < 4; t++) begin
      smp();
      chk($sformatf("to_wait_rvalid%0d", t), 32'(bus.m_rvalid_o), 32'h0);
      chk($sformatf("to_wait_pulse%0d", t), 32'(bus.timeout_o), 32'h0);
      nxt();
    end
    smp();
    chk("to_rvalid", 32'(bus.m_rvalid_o), 32'h2);
    chk("to_err", 32'(bus.m_err_o), 32'h1);
    chk("to_rdata", bus.m_rdata_o, 32'hDEAD_BEEF);
    chk("to_pulse", 32'(bus.timeout_o), 32'h1);
    nxt();
    bus.s_rvalid_i = 1'b1;
    bus.s_rdata_i = 32'h55;
    smp();
    chk("late_rvalid", 32'(bus.m_rvalid_o), 32'h0);
    chk("late_rdata", bus.m_rdata_o, 32'h0);
    chk("late_err", 32'(bus.m_err_o), 32'h0);
    nxt();
    // master 0 completes (prio -> 1), master 1 granted, then reset in WAIT_RSP
    idle();
    bus.m_req_i = 2'b01;
    bus.s_gnt_i = 1'b1;
    smp();
    chk("pre_gnt", 32'(bus.m_gnt_o), 32'h1);
    nxt();
    idle();
    bus.s_rvalid_i = 1'b1;
    smp();
    chk("pre_rvalid", 32'(bus.m_rvalid_o), 32'h1);
    nxt();
    idle();
    bus.m_req_i = 2'b10;
    bus.s_gnt_i = 1'b1;
    smp();
    chk("mid_gnt", 32'(bus.m_gnt_o), 32'h2);
    nxt();
    idle();
    bus.s_rvalid_i = 1'b1;
    bus.s_rdata_i = 32'h77;
    rst_ni = 1'b0;
    smp();
    chk("mid_rst_rvalid", 32'(bus.m_rvalid_o), 32'h0);
    chk("mid_rst_rdata", bus.m_rdata_o, 32'h0);
    chk("mid_rst_sreq", 32'(bus.s_req_o), 32'h0);
    nxt();
    rst_ni = 1'b1;
    idle();
    nxt();
    bus.m_req_i = 2'b11;
    bus.s_gnt_i = 1'b1;
    smp();
    chk("post_rst_gnt", 32'(bus.m_gnt_o), 32'h1);
    nxt();
    idle();
    nxt();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
